// File: rtl/operand_issue.sv
// operand_issue: consumer end of the decode buffer. Accepts one decoded
// instruction per cycle and reads its operands from the register file. A
// pending-register scoreboard holds back RAW/WAW hazards, and the instruction
// is issued through a registered valid/ready stage to execute.
// Optional feature: define OPERAND_ISSUE_WB_BYPASS_EN to let a same-cycle
// writeback resolve a hazard and supply the operand directly.
module operand_issue #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 37,
    parameter int NREG   = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      dec_valid,
    output logic                      dec_ready,
    input  logic                      rs1_valid_b,
    input  logic                      rs2_valid_b,
    input  logic [$clog2(NREG)-1:0]   rs1_b,
    input  logic [$clog2(NREG)-1:0]   rs2_b,
    input  logic [$clog2(NREG)-1:0]   rd_b,
    input  logic                      rd_we_b,
    input  logic [6:0]                opcode_b,
    input  logic [CTRL_W-1:0]         out_signal_b,
    input  logic [XLEN-1:0]           imm_b,
    output logic [$clog2(NREG)-1:0]   rf_rs1_addr,
    output logic [$clog2(NREG)-1:0]   rf_rs2_addr,
    input  logic [XLEN-1:0]           rf_rs1_data,
    input  logic [XLEN-1:0]           rf_rs2_data,
    input  logic                      wb_en,
    input  logic [$clog2(NREG)-1:0]   wb_rd,
    input  logic [XLEN-1:0]           wb_data,
    input  logic                      flush,
    output logic                      ex_valid,
    input  logic                      ex_ready,
    output logic [XLEN-1:0]           ex_op_a,
    output logic [XLEN-1:0]           ex_op_b,
    output logic [XLEN-1:0]           ex_imm,
    output logic [$clog2(NREG)-1:0]   ex_rd,
    output logic                      ex_rd_we,
    output logic [6:0]                ex_opcode,
    output logic [CTRL_W-1:0]         ex_ctrl,
    output logic [NREG-1:0]           sb_pending
);

    localparam int IDX_W = $clog2(NREG);

    typedef struct packed {
        logic [XLEN-1:0]   op_a;
        logic [XLEN-1:0]   op_b;
        logic [XLEN-1:0]   imm;
        logic [IDX_W-1:0]  rd;
        logic              rd_we;
        logic [6:0]        opcode;
        logic [CTRL_W-1:0] ctrl;
    } issue_t;

    issue_t          issue_q, issue_d;
    logic            ex_valid_q, ex_valid_d;
    logic [NREG-1:0] pending_q, pending_d;

    logic wb_hit_rs1, wb_hit_rs2, wb_hit_rd;
    logic busy_rs1, busy_rs2, busy_rd;
    logic stall;
    logic accept;

    assign rf_rs1_addr = rs1_b;
    assign rf_rs2_addr = rs2_b;

`ifdef OPERAND_ISSUE_WB_BYPASS_EN
    // A writeback landing this cycle satisfies a matching source or destination.
    assign wb_hit_rs1 = wb_en && (wb_rd == rs1_b) && (rs1_b != '0);
    assign wb_hit_rs2 = wb_en && (wb_rd == rs2_b) && (rs2_b != '0);
    assign wb_hit_rd  = wb_en && (wb_rd == rd_b)  && (rd_b  != '0);
`else
    logic wb_data_unused;
    assign wb_hit_rs1     = 1'b0;
    assign wb_hit_rs2     = 1'b0;
    assign wb_hit_rd      = 1'b0;
    assign wb_data_unused = ^wb_data;
`endif

    // Hazard detection and the decode-side handshake.
    always_comb begin
        busy_rs1  = pending_q[rs1_b] && !wb_hit_rs1;
        busy_rs2  = pending_q[rs2_b] && !wb_hit_rs2;
        busy_rd   = pending_q[rd_b]  && !wb_hit_rd;
        stall     = (rs1_valid_b && busy_rs1) || (rs2_valid_b && busy_rs2) ||
                    (rd_we_b && (rd_b != '0) && busy_rd);
        accept    = dec_valid && !stall && !flush && (!ex_valid_q || ex_ready);
        dec_ready = accept;
    end

    // Issue-register next state: load on accept, drop on drain or flush, else hold.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned, which would infer a latch.
        issue_d    = issue_q;
        ex_valid_d = ex_valid_q;
        if (accept) begin
            issue_d.op_a   = !rs1_valid_b ? '0 : (wb_hit_rs1 ? wb_data : rf_rs1_data);
            issue_d.op_b   = !rs2_valid_b ? '0 : (wb_hit_rs2 ? wb_data : rf_rs2_data);
            issue_d.imm    = imm_b;
            issue_d.rd     = rd_b;
            issue_d.rd_we  = rd_we_b;
            issue_d.opcode = opcode_b;
            issue_d.ctrl   = out_signal_b;
            ex_valid_d     = 1'b1;
        end else if (flush || ex_ready) begin
            ex_valid_d = 1'b0;
        end
    end

    // Scoreboard next state: clears first, so a same-cycle issue set wins.
    always_comb begin
        pending_d = pending_q;
        if (wb_en) begin
            pending_d[wb_rd] = 1'b0;
        end
        // A flushed instruction still sitting in the issue register never writes back.
        if (flush && ex_valid_q && issue_q.rd_we && !ex_ready) begin
            pending_d[issue_q.rd] = 1'b0;
        end
        if (accept && rd_we_b && (rd_b != '0)) begin
            pending_d[rd_b] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples its next-state value from before the edge.
        if (rst) begin
            // NOTE: the issue payload is reset as well because its outputs
            // must read zero after reset, not just ex_valid.
            issue_q    <= '0;
            ex_valid_q <= 1'b0;
            pending_q  <= '0;
        end else begin
            issue_q    <= issue_d;
            ex_valid_q <= ex_valid_d;
            pending_q  <= pending_d;
        end
    end

    assign ex_valid   = ex_valid_q;
    assign ex_op_a    = issue_q.op_a;
    assign ex_op_b    = issue_q.op_b;
    assign ex_imm     = issue_q.imm;
    assign ex_rd      = issue_q.rd;
    assign ex_rd_we   = issue_q.rd_we;
    assign ex_opcode  = issue_q.opcode;
    assign ex_ctrl    = issue_q.ctrl;
    assign sb_pending = pending_q;

endmodule

// File: tb/tb_operand_issue.sv
// Testbench for operand_issue: directed scenarios followed by randomized
// traffic. A reference model predicts the handshake, scoreboard and issued
// payloads; a monitor compares the issue register against a queue of
// expected instructions.
module tb_operand_issue;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 37;
    localparam int NREG   = 32;
`ifdef OPERAND_ISSUE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [XLEN-1:0]   a;
        logic [XLEN-1:0]   b;
        logic [XLEN-1:0]   imm;
        logic [4:0]        rd;
        logic              we;
        logic [6:0]        op;
        logic [CTRL_W-1:0] ctrl;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dec_valid = 1'b0, dec_ready;
    logic rs1_valid_b = 1'b0, rs2_valid_b = 1'b0;
    logic [4:0] rs1_b = '0, rs2_b = '0, rd_b = '0;
    logic rd_we_b = 1'b0;
    logic [6:0] opcode_b = '0;
    logic [CTRL_W-1:0] out_signal_b = '0;
    logic [XLEN-1:0] imm_b = '0;
    logic [4:0] rf_rs1_addr, rf_rs2_addr;
    logic [XLEN-1:0] rf_rs1_data, rf_rs2_data;
    logic wb_en = 1'b0;
    logic [4:0] wb_rd = '0;
    logic [XLEN-1:0] wb_data = '0;
    logic flush = 1'b0;
    logic ex_valid, ex_ready = 1'b0;
    logic [XLEN-1:0] ex_op_a, ex_op_b, ex_imm;
    logic [4:0] ex_rd;
    logic ex_rd_we;
    logic [6:0] ex_opcode;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [NREG-1:0] sb_pending;

    int checks = 0;
    int errors = 0;

    operand_issue #(.XLEN(XLEN), .CTRL_W(CTRL_W), .NREG(NREG)) dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .rs1_valid_b(rs1_valid_b), .rs2_valid_b(rs2_valid_b),
        .rs1_b(rs1_b), .rs2_b(rs2_b), .rd_b(rd_b), .rd_we_b(rd_we_b),
        .opcode_b(opcode_b), .out_signal_b(out_signal_b), .imm_b(imm_b),
        .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_imm(ex_imm),
        .ex_rd(ex_rd), .ex_rd_we(ex_rd_we), .ex_opcode(ex_opcode),
        .ex_ctrl(ex_ctrl), .sb_pending(sb_pending)
    );

    always #5 clk = ~clk;

    // Register file: async read, written by writebacks at the clock edge.
    logic [XLEN-1:0] rf [NREG];
    logic rf_loaded = 1'b0;
    always @(posedge clk) begin
        if (!rf_loaded) begin
            for (int i = 0; i < NREG; i++) rf[i] <= (i == 0) ? 32'h0 : 32'h100 + 32'(i * 17);
            rf[1] <= 32'd5;
            rf[2] <= 32'd7;
            rf_loaded <= 1'b1;
        end else if (wb_en && wb_rd != 5'd0) begin
            rf[wb_rd] <= wb_data;
        end
    end
    assign rf_rs1_data = rf[rf_rs1_addr];
    assign rf_rs2_data = rf[rf_rs2_addr];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: registers awaiting writeback, the instruction
    // currently held for execute, expected issues, and writebacks still owed.
    logic [NREG-1:0] m_pend = '0;
    logic            m_exv  = 1'b0;
    rec_t            m_ex   = '0;
    rec_t            exp_q [$];
    logic [4:0]      wbq [$];
    bit              auto_wb = 1'b0;

    function automatic bit busy(input logic [4:0] r);
        return m_pend[r] && !(BYP && wb_en && wb_rd == r);
    endfunction

    function automatic logic [XLEN-1:0] src_val(input logic v, input logic [4:0] r);
        if (!v) return '0;
        if (BYP && wb_en && wb_rd == r && r != 5'd0) return wb_data;
        return rf[r];
    endfunction

    // Model: predict the handshake and scoreboard, record expected issues.
    always @(negedge clk) begin : model
        rec_t r;
        logic [NREG-1:0] nxt;
        logic stall, exp_rdy;
        if (rst) begin
            m_pend = '0;
            m_exv  = 1'b0;
        end else begin
            stall = (rs1_valid_b && busy(rs1_b)) || (rs2_valid_b && busy(rs2_b)) ||
                    (rd_we_b && rd_b != 5'd0 && busy(rd_b));
            exp_rdy = dec_valid && !stall && !flush && (!m_exv || ex_ready);
            check("dec_ready", 64'(dec_ready), 64'(exp_rdy));
            check("sb_pending", 64'(sb_pending), 64'(m_pend));
            check("ex_valid", 64'(ex_valid), 64'(m_exv));
            nxt = m_pend;
            if (wb_en) nxt[wb_rd] = 1'b0;
            if (flush && m_exv && m_ex.we && !ex_ready) nxt[m_ex.rd] = 1'b0;
            if (m_exv && ex_ready && m_ex.we && m_ex.rd != 5'd0 && auto_wb) wbq.push_back(m_ex.rd);
            if (exp_rdy) begin
                r.a    = src_val(rs1_valid_b, rs1_b);
                r.b    = src_val(rs2_valid_b, rs2_b);
                r.imm  = imm_b;
                r.rd   = rd_b;
                r.we   = rd_we_b;
                r.op   = opcode_b;
                r.ctrl = out_signal_b;
                exp_q.push_back(r);
                m_ex  = r;
                m_exv = 1'b1;
                if (rd_we_b && rd_b != 5'd0) nxt[rd_b] = 1'b1;
            end else if (flush || ex_ready) begin
                m_exv = 1'b0;
            end
            nxt[0] = 1'b0;
            m_pend = nxt;
        end
    end

    // Monitor: whenever execute sees a valid instruction, compare it with the
    // oldest expected issue; retire it once taken or flushed.
    always @(negedge clk) begin : monitor
        rec_t e;
        if (rst) begin
            exp_q.delete();
        end else if (ex_valid) begin
            if (exp_q.size() == 0) begin
                check("ex_unexpected", 64'(ex_valid), 64'd0);
            end else begin
                e = exp_q[0];
                check("ex_op_a", 64'(ex_op_a), 64'(e.a));
                check("ex_op_b", 64'(ex_op_b), 64'(e.b));
                check("ex_imm", 64'(ex_imm), 64'(e.imm));
                check("ex_rd", 64'(ex_rd), 64'(e.rd));
                check("ex_rd_we", 64'(ex_rd_we), 64'(e.we));
                check("ex_opcode", 64'(ex_opcode), 64'(e.op));
                check("ex_ctrl", 64'(ex_ctrl), 64'(e.ctrl));
                if (ex_ready || flush) void'(exp_q.pop_front());
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                             input logic v1, input logic v2, input logic we);
        dec_valid    = 1'b1;
        rs1_b        = s1;
        rs2_b        = s2;
        rd_b         = d;
        rs1_valid_b  = v1;
        rs2_valid_b  = v2;
        rd_we_b      = we;
        opcode_b     = 7'($urandom());
        out_signal_b = CTRL_W'({$urandom(), $urandom()});
        imm_b        = $urandom();
    endtask

    task automatic drive_wb();
        if (wbq.size() > 0 && $urandom_range(0, 1) == 1) begin
            wb_en   = 1'b1;
            wb_rd   = wbq.pop_front();
            wb_data = $urandom();
        end else begin
            wb_en = 1'b0;
        end
    endtask

    task automatic random_instr();
        set_instr(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        dec_valid = ($urandom_range(0, 9) < 7);
    endtask

    initial begin
        repeat (3) next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("rst_ex_valid", 64'(ex_valid), 64'd0);
        check("rst_pending", 64'(sb_pending), 64'd0);
        check("rst_op_a", 64'(ex_op_a), 64'd0);
        check("rst_op_b", 64'(ex_op_b), 64'd0);
        check("rst_ctrl", 64'(ex_ctrl), 64'd0);

        // ADD x3 = x1 + x2
        next_cycle(); set_instr(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1); ex_ready = 1'b1;
        @(negedge clk); check("add_accept", 64'(dec_ready), 64'd1);
        next_cycle(); dec_valid = 1'b0; ex_ready = 1'b0;
        @(negedge clk);
        check("add_op_a", 64'(ex_op_a), 64'd5);
        check("add_op_b", 64'(ex_op_b), 64'd7);
        check("add_pend3", 64'(sb_pending[3]), 64'd1);

        // RAW on x3, released by a writeback of 0x20
        next_cycle(); set_instr(5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0); ex_ready = 1'b1;
        @(negedge clk); check("raw_stall0", 64'(dec_ready), 64'd0);
        next_cycle();
        @(negedge clk); check("raw_stall1", 64'(dec_ready), 64'd0);
        next_cycle(); wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'h20;
        @(negedge clk); check("raw_wb_cycle", 64'(dec_ready), 64'(BYP));
        next_cycle(); wb_en = 1'b0;
        if (BYP) begin
            dec_valid = 1'b0;
            @(negedge clk); check("raw_op_a", 64'(ex_op_a), 64'h20);
        end else begin
            @(negedge clk); check("raw_after_wb", 64'(dec_ready), 64'd1);
            next_cycle(); dec_valid = 1'b0;
            @(negedge clk); check("raw_op_a", 64'(ex_op_a), 64'h20);
        end

        // Backpressure: execute stalls for three cycles
        next_cycle(); set_instr(5'd1, 5'd2, 5'd6, 1'b1, 1'b1, 1'b1); ex_ready = 1'b1;
        next_cycle(); set_instr(5'd2, 5'd1, 5'd7, 1'b1, 1'b1, 1'b0); ex_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); check("hold_stall", 64'(dec_ready), 64'd0);
            next_cycle();
        end
        ex_ready = 1'b1;
        @(negedge clk); check("hold_release", 64'(dec_ready), 64'd1);
        next_cycle(); dec_valid = 1'b0;
        @(negedge clk); check("hold_next_op_a", 64'(ex_op_a), 64'd7);

        // Writer to x0 then reader of x0
        next_cycle(); set_instr(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clk); check("x0_writer", 64'(dec_ready), 64'd1);
        next_cycle(); set_instr(5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("x0_reader", 64'(dec_ready), 64'd1);
        check("x0_pend", 64'(sb_pending[0]), 64'd0);
        next_cycle(); dec_valid = 1'b0;
        @(negedge clk); check("x0_op_a", 64'(ex_op_a), 64'd0);

        // Flush kills a held writer to x5
        next_cycle(); set_instr(5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1); ex_ready = 1'b0;
        @(negedge clk); check("flush_issue", 64'(dec_ready), 64'd1);
        next_cycle(); dec_valid = 1'b0; flush = 1'b1;
        @(negedge clk); check("flush_pend_before", 64'(sb_pending[5]), 64'd1);
        next_cycle(); flush = 1'b0; set_instr(5'd5, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("flush_ex_valid", 64'(ex_valid), 64'd0);
        check("flush_pend_after", 64'(sb_pending[5]), 64'd0);
        check("flush_reader", 64'(dec_ready), 64'd1);
        next_cycle(); dec_valid = 1'b0; ex_ready = 1'b1;

        // New writer to x4 in the same cycle as the older writer's writeback
        next_cycle(); set_instr(5'd0, 5'd0, 5'd4, 1'b0, 1'b0, 1'b1);
        next_cycle(); set_instr(5'd0, 5'd0, 5'd4, 1'b0, 1'b0, 1'b1);
        wb_en = 1'b1; wb_rd = 5'd4; wb_data = $urandom();
        @(negedge clk); check("waw_wb_cycle", 64'(dec_ready), 64'(BYP));
        next_cycle(); dec_valid = 1'b0; wb_en = 1'b0;
        @(negedge clk); check("waw_pend4", 64'(sb_pending[4]), 64'(BYP));

        // Randomized traffic with an automatic writeback agent
        next_cycle(); rst = 1'b1; dec_valid = 1'b0;
        next_cycle(); next_cycle(); rst = 1'b0; auto_wb = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) begin
                // Mid-run reset; owed writebacks then drain as scoreboard no-ops.
                rst = 1'b1; dec_valid = 1'b0; wb_en = 1'b0;
                next_cycle(); next_cycle();
                rst = 1'b0;
                for (int k = 0; k < 200 && wbq.size() > 0; k++) begin
                    drive_wb();
                    next_cycle();
                end
                wb_en = 1'b0;
            end
            random_instr();
            flush    = ($urandom_range(0, 19) == 0);
            ex_ready = ($urandom_range(0, 9) < 7);
            drive_wb();
            next_cycle();
        end

        // Drain: no new work, execute always ready, all writebacks returned
        dec_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            drive_wb();
            next_cycle();
        end
        wb_en = 1'b0;
        next_cycle();
        @(negedge clk);
        check("drain_pending", 64'(sb_pending), 64'd0);
        check("drain_ex_valid", 64'(ex_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_issue.md
Name: operand_issue

Overview:
- Consumer end of the decode buffer, sitting between the decode buffer and the execute stage.
- Takes one decoded instruction per cycle from the buffer and reads both source operands from the register file.
- Tracks in-flight destination registers with a scoreboard and stalls on RAW/WAW hazards.
- Issues the instruction with its operands through a registered valid/ready stage to execute.

Parameters:
- XLEN, 32, datapath/operand width.
- CTRL_W, 37, width of the decoded control bundle.
- NREG, 32, number of architectural registers (index width = 5).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- dec_valid  in  1  decode buffer holds an instruction.
- dec_ready  out  1  instruction accepted this cycle (combinational).
- rs1_valid_b  in  1  instruction reads rs1.
- rs2_valid_b  in  1  instruction reads rs2.
- rs1_b  in  5  rs1 index.
- rs2_b  in  5  rs2 index.
- rd_b  in  5  destination index.
- rd_we_b  in  1  instruction writes rd.
- opcode_b  in  7  opcode.
- out_signal_b  in  CTRL_W  control bundle.
- imm_b  in  XLEN  immediate.
- rf_rs1_addr  out  5  regfile read address 1; equals rs1_b.
- rf_rs2_addr  out  5  regfile read address 2; equals rs2_b.
- rf_rs1_data  in  XLEN  async read data 1.
- rf_rs2_data  in  XLEN  async read data 2.
- wb_en  in  1  writeback this cycle.
- wb_rd  in  5  writeback index.
- wb_data  in  XLEN  writeback data.
- flush  in  1  kill the issue register and block acceptance.
- ex_valid  out  1  issue register valid.
- ex_ready  in  1  execute accepts.
- ex_op_a  out  XLEN  rs1 operand.
- ex_op_b  out  XLEN  rs2 operand.
- ex_imm  out  XLEN  immediate.
- ex_rd  out  5  destination index.
- ex_rd_we  out  1  destination write enable.
- ex_opcode  out  7  opcode.
- ex_ctrl  out  CTRL_W  control bundle.
- sb_pending  out  NREG  scoreboard (debug).

Behaviour:
- Reset: ex_valid=0, all ex_* data outputs=0, sb_pending=0.
- Scoreboard: pending[i]=1 from the cycle after issue of a writer to i until the cycle after wb_en with wb_rd==i. pending[0] is always 0; writers to x0 never set a bit.
- Hazards, with no bypass:
  - RAW stall if (rs1_valid_b & pending[rs1_b]) or (rs2_valid_b & pending[rs2_b]).
  - WAW stall if rd_we_b & rd_b!=0 & pending[rd_b].
  - A source equal to x0 never stalls.
- dec_ready = dec_valid & !stall & !flush & (!ex_valid | ex_ready).
- Acceptance (dec_ready=1 at cycle N):
  - Issue register loads at N+1: op_a=rf_rs1_data (0 if !rs1_valid_b), op_b=rf_rs2_data (0 if !rs2_valid_b), remaining fields copied; ex_valid=1 at N+1.
  - pending[rd_b] set at N+1 if rd_we_b & rd_b!=0.
- Hold: ex_valid & !ex_ready & !flush → all ex_* held stable; inputs are not sampled.
- Drain: ex_valid & ex_ready & no new accept → ex_valid=0 next cycle.
- Same-cycle set and clear of one index (issue of rd=i while wb_rd=i): set wins. The WAW stall guarantees the wb belongs to the older writer.
- Flush at cycle N:
  - ex_valid=0 at N+1.
  - If ex_valid & ex_rd_we & !ex_ready at N, pending[ex_rd] is cleared at N+1 (the killed instruction never writes back).
  - No accept at N. An instruction already taken by execute (ex_ready=1) keeps its bit.
- Flush and wb on the same index in the same cycle → bit cleared.
- Reset mid-operation: all state cleared next edge; in-flight writebacks after reset to a clear bit are no-ops on the scoreboard.
- Latency: one cycle decode→ex_valid when no hazard. Full throughput (1/cycle) with ex_ready held high.

Optional Feature:
- Macro: OPERAND_ISSUE_WB_BYPASS_EN.
- Enabled:
  - A source whose pending bit is set but which matches wb_en & wb_rd in the same cycle does not stall.
  - Its operand is taken from wb_data.
  - WAW against a same-cycle wb to rd_b also does not stall.
- Disabled:
  - Such a source stalls one extra cycle until the bit clears.
  - The operand is then read from the regfile, which must be written by that edge.

Test Plan:
- Reset, then issue ADD rs1=1,rs2=2,rd=3 (rf x1=5, x2=7), ex_ready=1 → ex_valid=1 next cycle, op_a=5, op_b=7, pending[3]=1.
- Issue rd=3 then a rs1=3 consumer with no wb → dec_ready=0 held. wb_en,wb_rd=3,wb_data=0x20 at cycle K:
  - Without bypass: dec_ready=1 at K+1 and op_a=regfile x3.
  - With bypass: dec_ready=1 at K and op_a=0x20.
- ex_ready=0 for 3 cycles with ex_valid=1 → ex_* stable and dec_ready=0. ex_ready=1 → next instruction loads at the following edge.
- Writer to x0 (rd=0,rd_we=1) followed by a reader of x0 → pending stays 0, no stall, op_a=0 when the regfile returns 0.
- Issue rd=5 with ex_ready=0, then flush → ex_valid=0 and pending[5]=0 next cycle. A subsequent rs1=5 reader is accepted immediately.
- Issue rd=4 with wb_en, wb_rd=4 in the same cycle from an older writer (bypass on) → pending[4]=1 after the edge.
